// File: rtl/life_loss_ctrl.sv
// Game-flow controller: folds the pixel-rate bottom-border hit into at most one
// life loss per frame and sequences IDLE/PLAY/RESPAWN/GAME_OVER/WIN.
module life_loss_ctrl #(
  parameter int INIT_LIVES         = 3,
  parameter int LIVES_W            = 3,
  parameter int RESPAWN_FRAMES     = 60,
  parameter int RESULT_HOLD_FRAMES = 30
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hitBottomBoarder,
  input  logic               allBricksCleared,
  input  logic               startKey,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         gameState,
  output logic               respawnPulse,
  output logic               freezeMotion,
  output logic               resultDrawingRequestEn,
  output logic               resultWin
);

  localparam int CNT_MAX = (RESPAWN_FRAMES > RESULT_HOLD_FRAMES) ? RESPAWN_FRAMES : RESULT_HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_GAME_OVER = 3'd3,
    S_WIN       = 3'd4
  } state_t;

  state_t             r_state, w_next;
  logic [LIVES_W-1:0] r_lives, w_lives_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_hit, w_hit_next;
  logic               r_key_released;
  logic               r_respawn, w_respawn_next;
  logic               r_freeze, r_result_en, r_result_win;
  logic               w_start_rise;
  logic               w_frame_hit;

  // The key history holds "key was low last cycle"; it resets to 0, so a key
  // held down through reset release has to be released before it counts.
  assign w_start_rise = startKey & r_key_released;
  assign w_frame_hit  = r_hit | hitBottomBoarder;

  always_comb begin
    w_next         = r_state;
    w_lives_next   = r_lives;
    w_cnt_next     = r_cnt;
    w_respawn_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_next         = S_PLAY;
          w_lives_next   = LIVES_W'(INIT_LIVES);
          w_cnt_next     = '0;
          w_respawn_next = 1'b1;
        end
      end
      S_PLAY: begin
        if (startOfFrame) begin
          if (allBricksCleared) begin
            w_next     = S_WIN;
            w_cnt_next = CNT_W'(RESULT_HOLD_FRAMES);
          end else if (w_frame_hit && (r_lives > LIVES_W'(1))) begin
            w_next         = S_RESPAWN;
            w_lives_next   = r_lives - LIVES_W'(1);
            w_cnt_next     = CNT_W'(RESPAWN_FRAMES);
            w_respawn_next = 1'b1;
          end else if (w_frame_hit) begin
            w_next       = S_GAME_OVER;
            w_lives_next = '0;
            w_cnt_next   = CNT_W'(RESULT_HOLD_FRAMES);
          end
        end
      end
      S_RESPAWN: begin
        if (startOfFrame) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_next     = S_PLAY;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (w_start_rise && (r_cnt == '0)) begin
          w_next       = S_IDLE;
          w_lives_next = LIVES_W'(INIT_LIVES);
        end else if (startOfFrame && (r_cnt != '0)) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase

    // Hits accumulate only within a PLAY frame; consumed at each frame start.
    w_hit_next = 1'b0;
    if ((r_state == S_PLAY) && (w_next == S_PLAY) && !startOfFrame)
      w_hit_next = w_frame_hit;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_IDLE;
      r_lives        <= LIVES_W'(INIT_LIVES);
      r_cnt          <= '0;
      r_hit          <= 1'b0;
      r_key_released <= 1'b0;
      r_respawn      <= 1'b0;
      r_freeze       <= 1'b1;
      r_result_en    <= 1'b0;
      r_result_win   <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_lives        <= w_lives_next;
      r_cnt          <= w_cnt_next;
      r_hit          <= w_hit_next;
      r_key_released <= ~startKey;
      r_respawn      <= w_respawn_next;
      r_freeze       <= (w_next != S_PLAY);
      r_result_en    <= (w_next == S_GAME_OVER) || (w_next == S_WIN);
      r_result_win   <= (w_next == S_WIN);
    end
  end

  assign gameState              = r_state;
  assign lives                  = r_lives;
  assign respawnPulse           = r_respawn;
  assign freezeMotion           = r_freeze;
  assign resultDrawingRequestEn = r_result_en;
  assign resultWin              = r_result_win;

endmodule

// File: tb/tb_life_loss_ctrl.sv
// Bench for life_loss_ctrl: directed game script plus random frames, every
// cycle compared against a rule-level game model.
module tb_life_loss_ctrl;

  localparam int INIT_LIVES = 3;
  localparam int LIVES_W    = 3;
  localparam int RESP_FR    = 60;
  localparam int HOLD_FR    = 30;
  localparam int FRAME_LEN  = 64;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               hitBottomBoarder = 1'b0;
  logic               allBricksCleared = 1'b0;
  logic               startKey = 1'b0;
  logic [LIVES_W-1:0] lives;
  logic [2:0]         gameState;
  logic               respawnPulse;
  logic               freezeMotion;
  logic               resultDrawingRequestEn;
  logic               resultWin;

  int n_checks = 0;
  int n_errors = 0;

  // game model: mode 0 idle,1 play,2 respawn,3 game over,4 win
  int m_mode = 0;
  int m_lives = INIT_LIVES;
  int m_frames_left = 0;
  bit m_frame_hit = 1'b0;
  bit m_key_was_up = 1'b0;
  bit m_pulse = 1'b0;

  life_loss_ctrl #(
    .INIT_LIVES(INIT_LIVES), .LIVES_W(LIVES_W),
    .RESPAWN_FRAMES(RESP_FR), .RESULT_HOLD_FRAMES(HOLD_FR)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .hitBottomBoarder(hitBottomBoarder), .allBricksCleared(allBricksCleared),
    .startKey(startKey), .lives(lives), .gameState(gameState),
    .respawnPulse(respawnPulse), .freezeMotion(freezeMotion),
    .resultDrawingRequestEn(resultDrawingRequestEn), .resultWin(resultWin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {state, lives, respawnPulse, freezeMotion, resultEn, resultWin}
  function automatic logic [31:0] dut_vec();
    return {22'd0, gameState, lives, respawnPulse, freezeMotion, resultDrawingRequestEn, resultWin};
  endfunction

  function automatic logic [31:0] pack(input int st, input int lv, input bit p, input bit f,
                                       input bit en, input bit w);
    logic [2:0]         s3;
    logic [LIVES_W-1:0] l3;
    s3 = st[2:0];
    l3 = lv[LIVES_W-1:0];
    return {22'd0, s3, l3, p, f, en, w};
  endfunction

  function automatic logic [31:0] model_vec();
    return pack(m_mode, m_lives, m_pulse, m_mode != 1, (m_mode == 3) || (m_mode == 4), m_mode == 4);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lives = INIT_LIVES; m_frames_left = 0;
    m_frame_hit = 1'b0; m_key_was_up = 1'b0; m_pulse = 1'b0;
  endtask

  // Applies the game rules for the inputs currently driven.
  task automatic model_step();
    bit press;
    bit ball_lost;
    int nxt;
    press     = startKey && m_key_was_up;
    ball_lost = m_frame_hit || hitBottomBoarder;
    nxt       = m_mode;
    m_pulse   = 1'b0;
    if (m_mode == 0) begin
      if (press) begin nxt = 1; m_lives = INIT_LIVES; m_pulse = 1'b1; end
    end else if (m_mode == 1) begin
      if (startOfFrame) begin
        if (allBricksCleared) begin nxt = 4; m_frames_left = HOLD_FR; end
        else if (ball_lost && m_lives > 1) begin
          nxt = 2; m_lives = m_lives - 1; m_frames_left = RESP_FR; m_pulse = 1'b1;
        end else if (ball_lost) begin
          nxt = 3; m_lives = 0; m_frames_left = HOLD_FR;
        end
      end
    end else if (m_mode == 2) begin
      if (startOfFrame) begin
        m_frames_left = m_frames_left - 1;
        if (m_frames_left <= 0) begin nxt = 1; m_frames_left = 0; end
      end
    end else begin
      if (press && m_frames_left == 0) begin nxt = 0; m_lives = INIT_LIVES; end
      else if (startOfFrame && m_frames_left > 0) m_frames_left = m_frames_left - 1;
    end
    m_frame_hit  = (m_mode == 1 && nxt == 1 && !startOfFrame) ? ball_lost : 1'b0;
    m_key_was_up = !startKey;
    m_mode       = nxt;
  endtask

  task automatic cyc(input bit sof, input bit hit);
    startOfFrame     = sof;
    hitBottomBoarder = hit;
    model_step();
    @(posedge clk);
    #1;
    check("model", dut_vec(), model_vec());
    startOfFrame     = 1'b0;
    hitBottomBoarder = 1'b0;
  endtask

  // Frame body with hits on two "lines" (40 cycles), closed by startOfFrame.
  task automatic run_frame(input int hit_mode);
    bit h;
    for (int c = 0; c < FRAME_LEN - 1; c++) begin
      if (hit_mode == 1)      h = ((c >= 8 && c < 28) || (c >= 40 && c < 60));
      else if (hit_mode == 2) h = ($urandom_range(0, 15) == 0);
      else                    h = 1'b0;
      cyc(1'b0, h);
    end
    cyc(1'b1, 1'b0);
  endtask

  task automatic run_frames(input int n, input int hit_mode);
    for (int f = 0; f < n; f++) run_frame(hit_mode);
  endtask

  task automatic press_key();
    startKey = 1'b1;
    cyc(1'b0, 1'b0);
    startKey = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_outs", dut_vec(), pack(0, 3, 0, 1, 0, 0));
    @(negedge clk);
    resetN = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    startKey = 1'b1;
    cyc(1'b0, 1'b0);
    check("start_play", dut_vec(), pack(1, 3, 1, 0, 0, 0));
    startKey = 1'b0;
    cyc(1'b0, 1'b0);
    check("pulse_one_cycle", dut_vec(), pack(1, 3, 0, 0, 0, 0));

    run_frame(1);
    check("single_decrement", dut_vec(), pack(2, 2, 1, 1, 0, 0));
    run_frames(RESP_FR - 1, 1);
    check("respawn_hold", dut_vec(), pack(2, 2, 0, 1, 0, 0));
    run_frame(1);
    check("respawn_done", dut_vec(), pack(1, 2, 0, 0, 0, 0));
    run_frame(0);
    check("clean_frame", dut_vec(), pack(1, 2, 0, 0, 0, 0));

    run_frame(1);
    run_frames(RESP_FR, 0);
    check("lives_one", dut_vec(), pack(1, 1, 0, 0, 0, 0));
    run_frame(1);
    check("game_over", dut_vec(), pack(3, 0, 0, 1, 1, 0));
    run_frames(10, 1);
    press_key();
    check("early_start_ignored", dut_vec(), pack(3, 0, 0, 1, 1, 0));
    run_frames(HOLD_FR - 10, 0);
    press_key();
    check("back_to_idle", dut_vec(), pack(0, 3, 0, 1, 0, 0));

    cyc(1'b0, 1'b0);
    press_key();
    run_frame(1);
    run_frames(RESP_FR, 0);
    allBricksCleared = 1'b1;
    run_frame(1);
    allBricksCleared = 1'b0;
    check("win_over_hit", dut_vec(), pack(4, 2, 0, 1, 1, 1));

    run_frames(HOLD_FR, 0);
    press_key();
    cyc(1'b0, 1'b0);
    press_key();
    run_frame(1);
    run_frames(RESP_FR - 25, 0);
    check("mid_respawn", dut_vec(), pack(2, 2, 0, 1, 0, 0));
    #3;
    startKey = 1'b1;
    resetN   = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), pack(0, 3, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    check("reset_held", dut_vec(), pack(0, 3, 0, 1, 0, 0));
    @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    check("held_key_no_start", dut_vec(), pack(0, 3, 0, 1, 0, 0));
    startKey = 1'b0;
    cyc(1'b0, 1'b0);

    for (int f = 0; f < 60; f++) begin
      startKey         = ($urandom_range(0, 3) == 0);
      allBricksCleared = ($urandom_range(0, 11) == 0);
      run_frame(2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
